img_load_sched: RTL
===================

# img_load_sched

Sequencer that loads one full 640x480 RGB565 frame from an SD-card image slot into the frame RAM. It sits between the SD controller's sector-read port (`rd_start_en` / `rd_sec_addr` / `rd_busy` / `rd_val_en`) and the frame-RAM write-address input, in the 50 MHz domain. It issues sector reads back-to-back and generates the RAM write address for every 16-bit word. It also detects stalled or short sector transfers and reports completion or error.

## Interface

Parameters:
- `SEC_PER_IMG`, default 1200: sectors per image (640*480*2 B / 512 B).
- `BASE_SEC`, default 32'd8192: sector address of slot 0.
- `TIMEOUT`, default 1024: maximum clocks from `rd_start_en` to `rd_busy` high.
- `WORDS_PER_SEC`, default 256: 16-bit words per sector.

Ports:
- `clk` in 1: 50 MHz clock; the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `init_done` in 1: SD card initialised.
- `load_req` in 1: single-cycle request to load a slot.
- `slot` in 2: image slot index, sampled with `load_req`.
- `rd_busy` in 1: SD controller is reading a sector.
- `rd_val_en` in 1: one 16-bit data word is valid this cycle.
- `rd_start_en` out 1: single-cycle sector-read strobe.
- `rd_sec_addr` out 32: sector address; stable from `rd_start_en` until the end of that sector.
- `ram_wr_addr` out 19: frame-RAM word address for the current `rd_val_en`.
- `loading` out 1: high from request acceptance until DONE or ERR.
- `load_done` out 1: single-cycle pulse after the last sector completes.
- `load_err` out 1: single-cycle pulse on abort.

## Operation

- States: IDLE, START, WAIT_BUSY, WAIT_DONE, NEXT, DONE, ERR.
- **IDLE**
  - When `load_req && init_done`: latch `slot`, set `rd_sec_addr = BASE_SEC + slot*SEC_PER_IMG` (32-bit, no overflow check), clear `sec_cnt`, `wrd_cnt` and `ram_wr_addr`, then go to START.
  - `load_req` with `init_done=0` is ignored.
- **START**: assert `rd_start_en` for exactly one cycle, clear the watchdog, go to WAIT_BUSY.
- **WAIT_BUSY**
  - `rd_busy=1` -> WAIT_DONE.
  - Watchdog reaches `TIMEOUT` -> ERR.
- **WAIT_DONE**
  - On `rd_busy=0`: if `wrd_cnt == WORDS_PER_SEC`, go to NEXT; otherwise go to ERR.
- **NEXT**
  - If `sec_cnt == SEC_PER_IMG-1` -> DONE.
  - Otherwise `sec_cnt+1`, `rd_sec_addr+1`, clear `wrd_cnt`, then START.
- **DONE**: pulse `load_done`, return to IDLE.
- **ERR**: pulse `load_err`, return to IDLE. `ram_wr_addr` holds its last value.
- Data counting:
  - `rd_val_en` in WAIT_BUSY or WAIT_DONE: `ram_wr_addr` increments after the word is written. The address presented with a word is the address that word uses; the first word of a load uses 0.
  - `wrd_cnt` saturates at `WORDS_PER_SEC+1`.
  - `ram_wr_addr` saturates at 2^19-1; a complete image ends at 307200.
  - `rd_val_en` in any other state is ignored.
- `load_req` while `loading=1` is ignored; there is no queueing.
- `init_done` falling while `loading=1` -> ERR next cycle. This takes priority over every other transition.
- `rst` at any time forces IDLE immediately and drops `rd_start_en`. The SD controller is expected to finish any in-flight sector harmlessly.

## Timing

- Reset values:
  - `rd_start_en`=0, `loading`=0, `load_done`=0, `load_err`=0.
  - `rd_sec_addr`=`BASE_SEC`, `ram_wr_addr`=0.
  - State IDLE; all counters 0.
- All outputs are registered.
- `load_req` in cycle N -> `loading`=1 in N+1, `rd_start_en`=1 in N+2.
- `rd_busy` falls in cycle M with a full sector -> NEXT in M+1 -> next `rd_start_en` in M+2, i.e. a 2-cycle inter-sector gap.
- After the last sector: `load_done` high in M+2 and `loading` low in M+3.
- Timeout: ERR is entered `TIMEOUT` cycles after `rd_start_en`; `load_err` is asserted in the following cycle.

## Test plan

- **Normal load.** `SEC_PER_IMG`=4, `BASE_SEC`=100, `slot`=2, model responds 256 words per sector.
  - Expect reads at 108, 109, 110, 111, exactly 4 `rd_start_en` pulses.
  - Final `ram_wr_addr`=1024; one `load_done`; `load_err` never asserted.
- **Short sector.** Model delivers 255 words on sector 1, then drops `rd_busy`.
  - Expect `load_err` pulse; no further `rd_start_en`; `ram_wr_addr`=511.
- **Stall timeout.** `TIMEOUT`=64, model never raises `rd_busy`.
  - Expect `load_err` exactly 65 cycles after `rd_start_en`; `loading`=0 afterwards.
- **Request filtering.** `load_req` with `init_done`=0, then `load_req` during an active load.
  - Expect both ignored: no extra `rd_start_en`, and the slot address is unchanged.
- **init_done drop.** Drop `init_done` mid-sector.
  - Expect ERR next cycle and `load_err` pulse; stray `rd_val_en` afterwards leaves `ram_wr_addr` unchanged.
- **Reset mid-load.** Assert `rst` during sector 2.
  - Expect every output at its reset value immediately; a subsequent `load_req` restarts at sector `BASE_SEC+slot*SEC_PER_IMG` with `ram_wr_addr`=0.

Source files
------------

// File: rtl/img_load_sched.sv
// img_load_sched: loads one RGB565 frame from an SD-card image slot into frame RAM.
// It issues sector reads back-to-back, generates the RAM word address for every
// 16-bit word, and flags stalled (no busy) or short sector transfers as errors.
module img_load_sched #(
  parameter int unsigned SEC_PER_IMG   = 1200,
  parameter logic [31:0] BASE_SEC      = 32'd8192,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned WORDS_PER_SEC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        load_req,
  input  logic [1:0]  slot,
  input  logic        rd_busy,
  input  logic        rd_val_en,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic [18:0] ram_wr_addr,
  output logic        loading,
  output logic        load_done,
  output logic        load_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SC_W = $clog2(SEC_PER_IMG + 1);
  localparam int WC_W = $clog2(WORDS_PER_SEC + 2);

  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [SC_W-1:0] SEC_LAST = SC_W'(SEC_PER_IMG - 1);
  localparam logic [WC_W-1:0] WC_FULL  = WC_W'(WORDS_PER_SEC);
  localparam logic [WC_W-1:0] WC_SAT   = WC_W'(WORDS_PER_SEC + 1);
  localparam logic [18:0]     ADDR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, START, WAIT_BUSY, WAIT_DONE, NEXT, DONE, ERR
  } state_t;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   sec_cnt, sec_cnt_nxt;
  logic [WC_W-1:0]   wrd_cnt, wrd_cnt_nxt;
  logic [WD_W-1:0]   wdog, wdog_nxt;
  logic [31:0]       sec_addr_nxt;
  logic [18:0]       wr_addr_nxt;
  logic              start_nxt, loading_nxt, done_nxt, err_nxt;

  // Next-state and next-output decode; every output is registered from these.
  // NEXT issues the following sector's strobe itself so that the gap between
  // the end of one sector and the next strobe is only two cycles.
  always_comb begin
    state_nxt    = state;
    sec_cnt_nxt  = sec_cnt;
    wrd_cnt_nxt  = wrd_cnt;
    wdog_nxt     = wdog;
    sec_addr_nxt = rd_sec_addr;
    wr_addr_nxt  = ram_wr_addr;
    start_nxt    = 1'b0;
    loading_nxt  = loading;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    if (rd_val_en && (state == WAIT_BUSY || state == WAIT_DONE)) begin
      if (wrd_cnt != WC_SAT) wrd_cnt_nxt = wrd_cnt + WC_W'(1);
      if (ram_wr_addr != ADDR_MAX) wr_addr_nxt = ram_wr_addr + 19'd1;
    end

    case (state)
      IDLE: begin
        if (load_req && init_done) begin
          sec_addr_nxt = BASE_SEC + 32'(slot) * 32'(SEC_PER_IMG);
          sec_cnt_nxt  = '0;
          wrd_cnt_nxt  = '0;
          wr_addr_nxt  = '0;
          loading_nxt  = 1'b1;
          state_nxt    = START;
        end
      end
      START: begin
        start_nxt = 1'b1;
        wdog_nxt  = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (rd_busy) state_nxt = WAIT_DONE;
        else if (wdog == WD_LAST) state_nxt = ERR;
        else wdog_nxt = wdog + WD_W'(1);
      end
      WAIT_DONE: begin
        if (!rd_busy) state_nxt = (wrd_cnt == WC_FULL) ? NEXT : ERR;
      end
      NEXT: begin
        if (sec_cnt == SEC_LAST) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          sec_cnt_nxt  = sec_cnt + SC_W'(1);
          sec_addr_nxt = rd_sec_addr + 32'd1;
          wrd_cnt_nxt  = '0;
          wdog_nxt     = '0;
          start_nxt    = 1'b1;
          state_nxt    = WAIT_BUSY;
        end
      end
      DONE: begin
        loading_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      ERR: begin
        err_nxt     = 1'b1;
        loading_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (!init_done && (state == START || state == WAIT_BUSY ||
                       state == WAIT_DONE || state == NEXT)) begin
      start_nxt = 1'b0;
      done_nxt  = 1'b0;
      state_nxt = ERR;
    end
  end

  // State, counters and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sec_cnt     <= '0;
      wrd_cnt     <= '0;
      wdog        <= '0;
      rd_sec_addr <= BASE_SEC;
      ram_wr_addr <= '0;
      rd_start_en <= 1'b0;
      loading     <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      sec_cnt     <= sec_cnt_nxt;
      wrd_cnt     <= wrd_cnt_nxt;
      wdog        <= wdog_nxt;
      rd_sec_addr <= sec_addr_nxt;
      ram_wr_addr <= wr_addr_nxt;
      rd_start_en <= start_nxt;
      loading     <= loading_nxt;
      load_done   <= done_nxt;
      load_err    <= err_nxt;
    end
  end

endmodule
